universal_shift_reg: RTL and testbench

//   Parametrised bank of D flip-flops with four modes: hold, shift right, shift left, parallel load.

---
 rtl/usr_pkg.sv | 16 +
 rtl/usr_bit_slice.sv | 47 ++++
 rtl/universal_shift_reg.sv | 111 +++++++++++
 tb/tb_universal_shift_reg.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usr_pkg.sv
// Shared types and helpers for the universal shift register.
package usr_pkg;

    typedef enum logic [1:0] {
        USR_HOLD = 2'b00,
        USR_SHR  = 2'b01,
        USR_SHL  = 2'b10,
        USR_LOAD = 2'b11
    } usr_mode_t;

    // Counter width able to hold the values 0..width
    function automatic int usr_cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/usr_bit_slice.sv
// One storage bit of the universal shift register: a flip-flop fed by a
// 4:1 mux choosing between itself, its left neighbour (shift right),
// its right neighbour (shift left) and the parallel load bit.
module usr_bit_slice
    import usr_pkg::*;
#(
    parameter logic RESET_BIT = 1'b0
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      en,
    input  usr_mode_t sel,
    input  logic      from_left,
    input  logic      from_right,
    input  logic      d_bit,
    output logic      q_bit
);

    logic next_s;
    logic q_r;

    // Next-state selection for this bit according to the operating mode
    always_comb begin
        next_s = q_r;
        case (sel)
            USR_HOLD: next_s = q_r;
            USR_SHR:  next_s = from_left;
            USR_SHL:  next_s = from_right;
            USR_LOAD: next_s = d_bit;
            default:  next_s = q_r;
        endcase
    end

    // Storage flop with synchronous reset and clock enable
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_r <= RESET_BIT;
        end else if (en) begin
            q_r <= next_s;
        end else begin
            q_r <= q_r;
        end
    end

    assign q_bit = q_r;

endmodule

// File: rtl/universal_shift_reg.sv
// Universal shift register: hold / shift right / shift left / parallel load,
// with complementary outputs, serial taps at both ends and a word-boundary
// pulse raised one cycle after every WIDTH-th shift since the last load/reset.
// Optional feature macro: USR_ROTATE_EN adds a 'rotate' input that recirculates
// the outgoing bit instead of taking the serial inputs.
module universal_shift_reg
    import usr_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             ser_in_r,
    input  logic             ser_in_l,
`ifdef USR_ROTATE_EN
    input  logic             rotate,
`endif
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn,
    output logic             ser_out_r,
    output logic             ser_out_l,
    output logic             word_done
);

    localparam int               CNT_W    = usr_cnt_w(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    usr_mode_t        mode_s;
    logic [WIDTH-1:0] q_s;
    logic [WIDTH-1:0] shr_src_s;
    logic [WIDTH-1:0] shl_src_s;
    logic             msb_feed_s;
    logic             lsb_feed_s;
    logic [CNT_W-1:0] shift_cnt_r;
    logic             word_done_r;

    assign mode_s = usr_mode_t'(mode);

`ifdef USR_ROTATE_EN
    assign msb_feed_s = rotate ? q_s[0]       : ser_in_r;
    assign lsb_feed_s = rotate ? q_s[WIDTH-1] : ser_in_l;
`else
    assign msb_feed_s = ser_in_r;
    assign lsb_feed_s = ser_in_l;
`endif

    // Per-bit sources for each shift direction, including the entering bit
    assign shr_src_s = {msb_feed_s, q_s[WIDTH-1:1]};
    assign shl_src_s = {q_s[WIDTH-2:0], lsb_feed_s};

    for (genvar i = 0; i < WIDTH; i++) begin : g_slice
        usr_bit_slice #(
            .RESET_BIT (RESET_VAL[i])
        ) u_slice (
            .clk        (clk),
            .rst_n      (rst_n),
            .en         (en),
            .sel        (mode_s),
            .from_left  (shr_src_s[i]),
            .from_right (shl_src_s[i]),
            .d_bit      (d[i]),
            .q_bit      (q_s[i])
        );
    end

    // Shift counter and word-boundary pulse; both directions share one count
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shift_cnt_r <= '0;
            word_done_r <= 1'b0;
        end else if (!en) begin
            shift_cnt_r <= shift_cnt_r;
            word_done_r <= 1'b0;
        end else begin
            case (mode_s)
                USR_SHR, USR_SHL: begin
                    if (shift_cnt_r == CNT_LAST) begin
                        shift_cnt_r <= '0;
                        word_done_r <= 1'b1;
                    end else begin
                        shift_cnt_r <= shift_cnt_r + CNT_W'(1);
                        word_done_r <= 1'b0;
                    end
                end
                USR_LOAD: begin
                    shift_cnt_r <= '0;
                    word_done_r <= 1'b0;
                end
                USR_HOLD: begin
                    shift_cnt_r <= shift_cnt_r;
                    word_done_r <= 1'b0;
                end
                default: begin
                    shift_cnt_r <= shift_cnt_r;
                    word_done_r <= 1'b0;
                end
            endcase
        end
    end

    assign q         = q_s;
    assign qn        = ~q_s;
    assign ser_out_r = q_s[0];
    assign ser_out_l = q_s[WIDTH-1];
    assign word_done = word_done_r;

endmodule

// File: tb/tb_universal_shift_reg.sv
// Self-checking bench for universal_shift_reg (WIDTH=8). A behavioural model
// pushes the expected register state at each driven cycle; each scenario
// task pops and compares once the DUT has updated.
module tb_universal_shift_reg;

    localparam int W = 8;

    typedef struct {
        logic       rst;
        logic       en;
        logic [1:0] mode;
        logic [7:0] d;
        logic       sr;
        logic       sl;
        logic       rot;
    } step_t;

    typedef struct {
        logic [7:0] q;
        logic       wd;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [7:0] d = 8'h00;
    logic       ser_in_r = 1'b0;
    logic       ser_in_l = 1'b0;
    logic       rotate = 1'b0;
    logic [7:0] q, qn, q2, qn2;
    logic       ser_out_r, ser_out_l, word_done;
    logic       ser_out_r2, ser_out_l2, word_done2;

    int n_run  = 0;
    int n_fail = 0;

    logic [7:0] m_q   = 8'h00;
    int         m_cnt = 0;
    logic       m_wd  = 1'b0;
    exp_t       sb[$];

    always #5 clk = ~clk;

    universal_shift_reg #(.WIDTH(W), .RESET_VAL(8'h00)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .d(d),
        .ser_in_r(ser_in_r), .ser_in_l(ser_in_l),
`ifdef USR_ROTATE_EN
        .rotate(rotate),
`endif
        .q(q), .qn(qn), .ser_out_r(ser_out_r), .ser_out_l(ser_out_l),
        .word_done(word_done)
    );

    universal_shift_reg #(.WIDTH(W), .RESET_VAL(8'h3C)) dut_rv (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .d(d),
        .ser_in_r(ser_in_r), .ser_in_l(ser_in_l),
`ifdef USR_ROTATE_EN
        .rotate(rotate),
`endif
        .q(q2), .qn(qn2), .ser_out_r(ser_out_r2), .ser_out_l(ser_out_l2),
        .word_done(word_done2)
    );

    function automatic step_t mk(logic r, logic e, logic [1:0] m, logic [7:0] dd,
                                 logic sr, logic sl, logic rot);
        step_t s;
        s.rst = r; s.en = e; s.mode = m; s.d = dd; s.sr = sr; s.sl = sl; s.rot = rot;
        return s;
    endfunction

    // Drive one cycle of stimulus and push the model's expected outcome
    task automatic drive(input step_t s);
        exp_t e;
        logic in_r, in_l;
        rst_n = ~s.rst; en = s.en; mode = s.mode; d = s.d;
        ser_in_r = s.sr; ser_in_l = s.sl; rotate = s.rot;
        in_r = s.sr;
        in_l = s.sl;
`ifdef USR_ROTATE_EN
        if (s.rot) begin
            in_r = m_q[0];
            in_l = m_q[7];
        end
`endif
        if (s.rst) begin
            m_q = 8'h00; m_cnt = 0; m_wd = 1'b0;
        end else if (!s.en) begin
            m_wd = 1'b0;
        end else if (s.mode == 2'b11) begin
            m_q = s.d; m_cnt = 0; m_wd = 1'b0;
        end else if (s.mode == 2'b00) begin
            m_wd = 1'b0;
        end else begin
            if (s.mode == 2'b01) m_q = {in_r, m_q[7:1]};
            else                 m_q = {m_q[6:0], in_l};
            m_cnt = m_cnt + 1;
            m_wd = (m_cnt == W);
            if (m_cnt == W) m_cnt = 0;
        end
        e.q = m_q; e.wd = m_wd;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        exp_t e;
        step_t s[$];
        s.push_back(mk(1'b1, 1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 1'b0));
        s.push_back(mk(1'b0, 1'b1, 2'b11, 8'hA5, 1'b0, 1'b0, 1'b0));
        s.push_back(mk(1'b1, 1'b1, 2'b11, 8'hA5, 1'b1, 1'b1, 1'b0));
        foreach (s[i]) begin
            drive(s[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            n_run++;
            if (q !== e.q || word_done !== e.wd || qn !== ~e.q) begin
                n_fail++;
                $display("FAIL reset step %0d: q=%h qn=%h wd=%b, expected q=%h qn=%h wd=%b",
                         i, q, qn, word_done, e.q, ~e.q, e.wd);
            end
        end
        n_run++;
        if (q !== 8'h00 || qn !== 8'hFF) begin
            n_fail++;
            $display("FAIL reset_value: q=%h qn=%h, expected 00/FF", q, qn);
        end
        n_run++;
        if (q2 !== 8'h3C || word_done2 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_val_3c: q=%h wd=%b, expected 3c/0", q2, word_done2);
        end
    endtask

    task automatic test_shr();
        exp_t e;
        logic [7:0] seq_v;
        int pulses;
        seq_v = 8'h96;
        pulses = 0;
        drive(mk(1'b0, 1'b1, 2'b11, 8'h96, 1'b0, 1'b0, 1'b0));
        @(posedge clk); #1;
        e = sb.pop_front();
        for (int i = 0; i < 9; i++) begin
            if (i < 8) begin
                n_run++;
                if (ser_out_r !== seq_v[i]) begin
                    n_fail++;
                    $display("FAIL shr_ser_out bit %0d: got %b, expected %b", i, ser_out_r, seq_v[i]);
                end
                drive(mk(1'b0, 1'b1, 2'b01, 8'h00, 1'b1, 1'b0, 1'b0));
            end else begin
                drive(mk(1'b0, 1'b1, 2'b00, 8'h00, 1'b0, 1'b0, 1'b0));
            end
            @(posedge clk); #1;
            e = sb.pop_front();
            n_run++;
            if (q !== e.q || word_done !== e.wd || ser_out_l !== e.q[7]) begin
                n_fail++;
                $display("FAIL shr step %0d: q=%h wd=%b, expected q=%h wd=%b", i, q, word_done, e.q, e.wd);
            end
            if (word_done === 1'b1) begin
                pulses++;
                n_run++;
                if (i != 7) begin
                    n_fail++;
                    $display("FAIL shr_wd_timing: pulse after step %0d, expected after step 7", i);
                end
            end
            if (i == 7) begin
                n_run++;
                if (q !== 8'hFF) begin
                    n_fail++;
                    $display("FAIL shr_final: q=%h, expected ff", q);
                end
            end
        end
        n_run++;
        if (pulses != 1) begin
            n_fail++;
            $display("FAIL shr_pulses: %0d pulses, expected 1", pulses);
        end
    endtask

    task automatic test_shl_enable();
        exp_t e;
        step_t s[$];
        int pulses;
        pulses = 0;
        s.push_back(mk(1'b0, 1'b1, 2'b11, 8'h01, 1'b0, 1'b0, 1'b0));
        for (int i = 0; i < 3; i++) s.push_back(mk(1'b0, 1'b1, 2'b10, 8'h00, 1'b1, 1'b0, 1'b0));
        for (int i = 0; i < 2; i++) s.push_back(mk(1'b0, 1'b0, 2'b10, 8'hFF, 1'b1, 1'b1, 1'b0));
        for (int i = 0; i < 5; i++) s.push_back(mk(1'b0, 1'b1, 2'b10, 8'h00, 1'b1, 1'b0, 1'b0));
        foreach (s[i]) begin
            drive(s[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            n_run++;
            if (q !== e.q || word_done !== e.wd || ser_out_r !== e.q[0]) begin
                n_fail++;
                $display("FAIL shl_en step %0d: q=%h wd=%b, expected q=%h wd=%b", i, q, word_done, e.q, e.wd);
            end
            if (word_done === 1'b1) pulses++;
        end
        n_run++;
        if (q !== 8'h00 || word_done !== 1'b1 || pulses != 1) begin
            n_fail++;
            $display("FAIL shl_en_final: q=%h wd=%b pulses=%0d, expected q=00 wd=1 pulses=1", q, word_done, pulses);
        end
    endtask

    task automatic test_load_clears();
        exp_t e;
        step_t s[$];
        int pulses;
        pulses = 0;
        for (int i = 0; i < 5; i++) s.push_back(mk(1'b0, 1'b1, 2'b01, 8'h00, 1'b1, 1'b0, 1'b0));
        s.push_back(mk(1'b0, 1'b1, 2'b11, 8'h55, 1'b0, 1'b0, 1'b0));
        for (int i = 0; i < 8; i++) s.push_back(mk(1'b0, 1'b1, 2'b10, 8'h00, 1'b0, 1'b0, 1'b0));
        foreach (s[i]) begin
            drive(s[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            n_run++;
            if (q !== e.q || word_done !== e.wd) begin
                n_fail++;
                $display("FAIL load_clr step %0d: q=%h wd=%b, expected q=%h wd=%b", i, q, word_done, e.q, e.wd);
            end
            if (word_done === 1'b1 && i != 13) pulses++;
        end
        n_run++;
        if (q !== 8'h00 || word_done !== 1'b1 || pulses != 0) begin
            n_fail++;
            $display("FAIL load_clr_final: q=%h wd=%b early=%0d, expected q=00 wd=1 early=0", q, word_done, pulses);
        end
    endtask

    task automatic test_reset_midword();
        exp_t e;
        step_t s[$];
        int pulses;
        pulses = 0;
        for (int i = 0; i < 4; i++) s.push_back(mk(1'b0, 1'b1, 2'b01, 8'h00, 1'b1, 1'b0, 1'b0));
        s.push_back(mk(1'b1, 1'b1, 2'b01, 8'h00, 1'b1, 1'b0, 1'b0));
        for (int i = 0; i < 7; i++) s.push_back(mk(1'b0, 1'b1, 2'b01, 8'h00, 1'b1, 1'b0, 1'b0));
        foreach (s[i]) begin
            drive(s[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            n_run++;
            if (q !== e.q || word_done !== e.wd) begin
                n_fail++;
                $display("FAIL rst_mid step %0d: q=%h wd=%b, expected q=%h wd=%b", i, q, word_done, e.q, e.wd);
            end
            if (word_done === 1'b1) pulses++;
        end
        n_run++;
        if (pulses != 0) begin
            n_fail++;
            $display("FAIL rst_mid_early: %0d pulses, expected 0", pulses);
        end
        drive(mk(1'b0, 1'b1, 2'b01, 8'h00, 1'b1, 1'b0, 1'b0));
        @(posedge clk); #1;
        e = sb.pop_front();
        n_run++;
        if (word_done !== 1'b1 || q !== e.q) begin
            n_fail++;
            $display("FAIL rst_mid_pulse: q=%h wd=%b, expected q=%h wd=1", q, word_done, e.q);
        end
    endtask

`ifdef USR_ROTATE_EN
    task automatic test_rotate();
        exp_t e;
        int pulses;
        pulses = 0;
        drive(mk(1'b0, 1'b1, 2'b11, 8'h81, 1'b0, 1'b0, 1'b0));
        @(posedge clk); #1;
        e = sb.pop_front();
        drive(mk(1'b0, 1'b1, 2'b10, 8'h00, 1'b0, 1'b0, 1'b1));
        @(posedge clk); #1;
        e = sb.pop_front();
        n_run++;
        if (q !== 8'h03 || q !== e.q) begin
            n_fail++;
            $display("FAIL rot_shl: q=%h, expected 03", q);
        end
        for (int i = 0; i < 8; i++) begin
            drive(mk(1'b0, 1'b1, 2'b01, 8'h00, 1'b0, 1'b1, 1'b1));
            @(posedge clk); #1;
            e = sb.pop_front();
            n_run++;
            if (q !== e.q || word_done !== e.wd) begin
                n_fail++;
                $display("FAIL rot_shr step %0d: q=%h wd=%b, expected q=%h wd=%b", i, q, word_done, e.q, e.wd);
            end
            if (word_done === 1'b1) pulses++;
        end
        n_run++;
        if (q !== 8'h03 || pulses != 1) begin
            n_fail++;
            $display("FAIL rot_final: q=%h pulses=%0d, expected 03/1", q, pulses);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_shr();
        test_shl_enable();
        test_load_clears();
        test_reset_midword();
`ifdef USR_ROTATE_EN
        test_rotate();
`endif
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
